// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Registers at BASE_ADDR: +0 TXDATA, +4 STATUS, +8 CTRL.
module mmio_uart_tx #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W = 32,
  parameter logic [DM_ADDRESS-1:0] BASE_ADDR = 9'h1F0,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  reade,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  hit,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  tx,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            full, empty, push_req, push, pop;
  logic            enable, ovf;
  logic [DM_ADDRESS:0] off;
  logic            sel_tx, sel_st, sel_ct;
  logic [AW+4:0]   cnt_w;
  logic [3:0]      cnt_sat;
  logic [7:0]      status;
  logic            unused_bits;

  assign unused_bits = ^wr_data[DATA_W-1:8];

  // Widened subtraction so addresses below BASE_ADDR cannot alias in.
  assign off = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign hit = (addr >= BASE_ADDR) &&
               (off <= (DM_ADDRESS+1)'(8)) &&
               (off[1:0] == 2'b00);
  assign sel_tx = hit && (off[3:2] == 2'd0);
  assign sel_st = hit && (off[3:2] == 2'd1);
  assign sel_ct = hit && (off[3:2] == 2'd2);

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign push_req = wr && sel_tx;
  assign push     = push_req && !full;
  assign busy     = (state != IDLE) || !empty;

  assign cnt_w   = (AW+5)'(count);
  assign cnt_sat = (cnt_w > (AW+5)'(15)) ? 4'hF : cnt_w[3:0];
  assign status  = {cnt_sat, ovf, state != IDLE, empty, full};

  always_comb begin
    rd_data = '0;
    if (reade) begin
      unique case (1'b1)
        sel_st:  rd_data[7:0] = status;
        sel_ct:  rd_data[0]   = enable;
        default: rd_data      = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (wr && sel_ct) enable <= wr_data[0];
      if (push_req && full)
        ovf <= 1'b1;
      else if (wr && sel_st && wr_data[3])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // tx is registered from the next state so START shows on the pop edge.
  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    pop     = 1'b0;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (enable && !empty) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          state_n = START;
          bit_n   = '0;
        end
      end
      START: begin
        if (baud == BAUD_MAX) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (baud == BAUD_MAX) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud == BAUD_MAX) begin
          state_n = IDLE;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized bench with a line-level UART receiver
// and a byte scoreboard for mmio_uart_tx.
module tb_mmio_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 8;
  localparam logic [8:0] BASE = 9'h1F0;
  localparam logic [8:0] A_TX = BASE;
  localparam logic [8:0] A_ST = BASE + 9'd4;
  localparam logic [8:0] A_CT = BASE + 9'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic        reade = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic        hit;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit mon_en = 1'b1;
  logic [7:0] mon_b;

  mmio_uart_tx #(
    .DM_ADDRESS(9), .DATA_W(32), .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .reade(reade),
    .addr(addr), .wr_data(wr_data), .hit(hit),
    .rd_data(rd_data), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Receiver: start seen at first low cycle, sample mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        repeat (CPB + CPB/2) @(negedge clk);
        mon_b[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back({tx, mon_b});
      end
    end
  end

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [8:0] a, output logic [31:0] d,
                          output logic h);
    addr = a; reade = 1'b1;
    #1;
    d = rd_data; h = hit;
    reade = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] st_val(int cnt, bit ovf, bit act);
    int c = (cnt > 15) ? 15 : cnt;
    return 32'(c * 16 + (ovf ? 8 : 0) + (act ? 4 : 0) +
               (cnt == 0 ? 2 : 0) + (cnt == DEPTH ? 1 : 0));
  endfunction

  task automatic wait_drain(input string nm);
    int n = 0;
    while (busy && n < 3000) begin @(posedge clk); #1; n++; end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: busy=%b want 0 after %0d cycles", nm, busy, n);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d; logic h;
    reset = 1'b1;
    addr = A_TX; wr_data = 32'h55; wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr = 1'b0; reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    bus_read(A_ST, d, h);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 2", d); end
    bus_read(A_CT, d, h);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl: got %h want 1", d); end
  endtask

  task automatic test_bad_addr;
    logic [31:0] d; logic h;
    logic [8:0] bad [3];
    bad[0] = BASE + 9'hC; bad[1] = BASE + 9'd1; bad[2] = BASE + 9'd6;
    foreach (bad[i]) begin
      bus_read(bad[i], d, h);
      checks++;
      if (h !== 1'b0 || d !== 32'h0) begin
        errors++;
        $display("FAIL bad_read %h: hit=%b rd=%h want 0/0", bad[i], h, d);
      end
      bus_write(bad[i], 32'h0);
    end
    bus_write(BASE + 9'd9, 32'h0);
    bus_write(BASE - 9'd4, 32'h0);
    bus_read(A_ST, d, h);
    checks++;
    if (d !== 32'h2 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_write_status: got %h busy=%b want 2/0", d, busy);
    end
    bus_read(A_CT, d, h);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL bad_write_ctrl: got %h want 1", d); end
    bus_read(A_TX, d, h);
    checks++;
    if (h !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL txdata_read: hit=%b rd=%h want 1/0", h, d);
    end
    addr = A_CT; reade = 1'b0; #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL no_reade: rd=%h want 0", rd_data);
    end
  endtask

  task automatic test_frame_a5;
    logic [9:0] frame = {1'b1, 8'hA5, 1'b0};
    int bad = 0;
    rx_q.delete();
    bus_write(A_TX, 32'hA5);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL latency_early: tx=%b want 1", tx); end
    for (int k = 0; k < 10 * CPB; k++) begin
      @(posedge clk); #1;
      if (tx !== frame[k / CPB]) begin
        if (bad == 0)
          $display("FAIL frame_a5 cycle %0d: tx=%b want %b", k, tx, frame[k / CPB]);
        bad++;
      end
      if (k == 10 * CPB - 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_last: got %b want 1", busy); end
      end
    end
    checks++;
    if (bad != 0) errors++;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL busy_end: busy=%b tx=%b want 0/1", busy, tx);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h1A5) begin
      errors++; $display("FAIL rx_a5: frames=%0d want 1 (0x1a5)", rx_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b1 = 8'($urandom);
    logic [7:0] b2 = 8'($urandom);
    logic s39, s40, s41;
    bit bad = 0;
    rx_q.delete(); exp_q.delete();
    exp_q.push_back(b1); exp_q.push_back(b2);
    bus_write(A_TX, 32'(b1));
    bus_write(A_TX, 32'(b2));
    for (int k = 1; k <= 10 * CPB + 1; k++) begin
      @(posedge clk); #1;
      if (k == 10 * CPB - 1) s39 = tx;
      if (k == 10 * CPB) s40 = tx;
      if (k == 10 * CPB + 1) s41 = tx;
    end
    checks++;
    if ({s39, s40, s41} !== 3'b110) begin
      errors++; $display("FAIL b2b_gap: stop/idle/start=%b%b%b want 110", s39, s40, s41);
    end
    wait_drain("b2b");
    checks++;
    if (rx_q.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[i]) if (rx_q[i] !== {1'b1, exp_q[i]}) bad = 1;
    if (bad) begin
      errors++; $display("FAIL b2b_data: frames=%0d want %0d", rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(1, DEPTH);
      bit bad = 0;
      rx_q.delete(); exp_q.delete();
      for (int j = 0; j < n; j++) begin
        logic [7:0] b = 8'($urandom);
        int gap = $urandom_range(0, 3 * CPB * 10 / 2);
        exp_q.push_back(b);
        bus_write(A_TX, {24'($urandom), b});
        repeat (gap) begin @(posedge clk); #1; end
      end
      wait_drain("random");
      checks++;
      if (rx_q.size() != exp_q.size()) bad = 1;
      else foreach (exp_q[i]) if (rx_q[i] !== {1'b1, exp_q[i]}) bad = 1;
      if (bad) begin
        errors++;
        $display("FAIL random_%0d: frames=%0d want %0d", it, rx_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_enable_midframe;
    logic [31:0] d; logic h;
    rx_q.delete();
    bus_write(A_TX, 32'h3C);
    repeat (10) @(posedge clk);
    #1;
    bus_write(A_CT, 32'h0);
    bus_write(A_TX, 32'hC3);
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h13C) begin
      errors++; $display("FAIL en_mid_frame: frames=%0d want 1 (0x13c)", rx_q.size());
    end
    bus_read(A_ST, d, h);
    checks++;
    if (d !== st_val(1, 0, 0) || busy !== 1'b1) begin
      errors++; $display("FAIL en_off_hold: status=%h busy=%b want %h/1", d, busy, st_val(1, 0, 0));
    end
    bus_write(A_CT, 32'h1);
    wait_drain("en_mid");
    checks++;
    if (rx_q.size() != 2 || rx_q[1] !== 9'h1C3) begin
      errors++; $display("FAIL en_resume: frames=%0d want 2", rx_q.size());
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d; logic h;
    bit bad = 0;
    rx_q.delete(); exp_q.delete();
    bus_write(A_CT, 32'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      bus_write(A_TX, 32'(i));
      if (i < DEPTH) exp_q.push_back(8'(i));
      bus_read(A_ST, d, h);
      checks++;
      if (d !== st_val((i < DEPTH) ? i + 1 : DEPTH, i == DEPTH, 0)) begin
        errors++;
        $display("FAIL fill_%0d: status=%h want %h", i, d,
                 st_val((i < DEPTH) ? i + 1 : DEPTH, i == DEPTH, 0));
      end
    end
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, d, h);
    checks++;
    if (d !== st_val(DEPTH, 0, 0)) begin
      errors++; $display("FAIL ovf_clear: status=%h want %h", d, st_val(DEPTH, 0, 0));
    end
    bus_write(A_CT, 32'h1);
    wait_drain("overflow");
    checks++;
    if (rx_q.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[i]) if (rx_q[i] !== {1'b1, exp_q[i]}) bad = 1;
    if (bad) begin
      errors++; $display("FAIL ovf_order: frames=%0d want %0d", rx_q.size(), exp_q.size());
    end
  endtask

  task automatic test_pop_collide;
    logic [31:0] d; logic h;
    for (int fill = DEPTH; fill >= DEPTH - 1; fill--) begin
      logic [7:0] extra = 8'($urandom);
      bit bad = 0;
      rx_q.delete(); exp_q.delete();
      bus_write(A_CT, 32'h0);
      for (int j = 0; j < fill; j++) begin
        logic [7:0] b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(A_TX, 32'(b));
      end
      bus_write(A_CT, 32'h1);
      bus_write(A_TX, 32'(extra));
      if (fill < DEPTH) exp_q.push_back(extra);
      bus_read(A_ST, d, h);
      checks++;
      if (d !== st_val(DEPTH - 1, fill == DEPTH, 1)) begin
        errors++;
        $display("FAIL collide_%0d: status=%h want %h", fill, d,
                 st_val(DEPTH - 1, fill == DEPTH, 1));
      end
      bus_write(A_ST, 32'h8);
      wait_drain("collide");
      checks++;
      if (rx_q.size() != exp_q.size()) bad = 1;
      else foreach (exp_q[i]) if (rx_q[i] !== {1'b1, exp_q[i]}) bad = 1;
      if (bad) begin
        errors++;
        $display("FAIL collide_data_%0d: frames=%0d want %0d", fill, rx_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d; logic h;
    bit stay = 1'b1;
    mon_en = 1'b0;
    bus_write(A_TX, 32'hF7);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    repeat (4 * CPB) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_bit3: tx=%b want 0", tx); end
    reset = 1'b1;
    addr = A_TX; wr_data = 32'h99; wr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx: tx=%b want 1", tx); end
    reset = 1'b0; wr = 1'b0;
    bus_read(A_ST, d, h);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL reset_mid_status: got %h want 2", d); end
    bus_read(A_CT, d, h);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_mid_ctrl: got %h want 1", d); end
    for (int k = 0; k < 12 * CPB; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) stay = 1'b0;
    end
    checks++;
    if (!stay) begin errors++; $display("FAIL reset_mid_quiet: line not idle, want tx=1 busy=0"); end
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bad_addr();
    test_frame_a5();
    test_back_to_back();
    test_random();
    test_enable_midframe();
    test_overflow();
    test_pop_collide();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, data-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, data-bus data width.
REQ-003 SHALL have parameter BASE_ADDR, default 9'h1F0, byte address of register block.
REQ-004 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (>=2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2).
REQ-006 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high.
REQ-008 SHALL have port wr  input  1  store strobe from EX/MEM stage.
REQ-009 SHALL have port reade  input  1  load strobe from EX/MEM stage.
REQ-010 SHALL have port addr  input  DM_ADDRESS  byte address.
REQ-011 SHALL have port wr_data  input  DATA_W  store data.
REQ-012 SHALL have port hit  output  1  combinational; high when addr is in BASE_ADDR..BASE_ADDR+8 and word-aligned.
REQ-013 SHALL have port rd_data  output  DATA_W  combinational load data; 0 when !reade or !hit.
REQ-014 SHALL have port tx  output  1  registered serial line, idle high.
REQ-015 SHALL have port busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-016 Register map: BASE+0 TXDATA (W: push wr_data[7:0]; R: 0); BASE+4 STATUS (R); BASE+8 CTRL (R/W).
REQ-017 STATUS read value: bit0 full, bit1 empty, bit2 FSM not IDLE, bit3 overflow sticky, bits[7:4] FIFO count (saturating at 15), others 0.
REQ-018 Writing STATUS with wr_data[3]=1 SHALL clear overflow; other STATUS bits are read-only.
REQ-019 CTRL bit0 = enable; reads return {31'b0, enable}; writes load wr_data[0].
REQ-020 A store to TXDATA when not full SHALL push the byte at that clock edge; count increments by 1.
REQ-021 A store to TXDATA when full (count sampled before the edge) SHALL drop the byte and set overflow.
REQ-022 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-024 wr and reade with !hit, or misaligned addresses, SHALL have no effect.
REQ-025 FSM states: IDLE, START, DATA, STOP.
REQ-026 IDLE -> START when enable=1 and FIFO not empty; pop the head into the shift register on that edge.
REQ-027 START drives tx=0 for CLKS_PER_BIT cycles, then -> DATA.
REQ-028 DATA shifts 8 bits LSB first, each held CLKS_PER_BIT cycles, then -> STOP.
REQ-029 STOP drives tx=1 for CLKS_PER_BIT cycles, then -> IDLE.
REQ-030 A frame SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back bytes SHALL get one IDLE cycle between the stop and next start.
REQ-031 Latency: a push at edge N with an idle FSM SHALL produce tx=0 from the cycle after edge N+1.
REQ-032 Clearing enable mid-frame SHALL finish the current frame; no new pop occurs while enable=0.
REQ-033 Bit counter and baud counter SHALL reset to 0 on each state entry.

Reset
REQ-034 Reset SHALL set tx=1, FSM=IDLE, FIFO empty, pointers 0, overflow=0, and enable=1.
REQ-035 Reset SHALL take priority over all bus activity in the same cycle.
REQ-036 Reset mid-frame SHALL abort the frame, discard FIFO contents, and return tx to 1 at the next edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-037 Store 0xA5 to BASE+0 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; busy drops after 40 cycles of frame.
REQ-038 Nine stores 0x00..0x08 while enable=0 -> STATUS reads full=1, count=8, overflow=1; set enable=1 -> bytes 0x00..0x07 transmitted in order, 0x08 absent.
REQ-039 Write STATUS with 0x8 -> overflow=0; other STATUS bits unchanged.
REQ-040 Push on the same cycle the FSM pops, with FIFO at count 8 -> push dropped; at count 7 -> accepted, count stays 7.
REQ-041 Assert reset during DATA bit 3 -> next cycle tx=1, STATUS=0x02, CTRL=0x1.
REQ-042 Load from BASE+0x0C or BASE+1 -> hit=0, rd_data=0, no state change.
